alu_ctrl_queue: RTL and testbench

- Sequential producer of the 4-bit ALU operation code consumed by the ALU's ctrl_i input.
- Accepts (ALUOp, funct) pairs from the decode stage over a valid/ready handshake and decodes them into the ALU encoding.
- Queues decoded entries in a small FIFO and presents them to the EX stage over a second valid/ready handshake.
- Decouples decode from EX stalls; is the encoder side of the ALU control interface.

---
 rtl/alu_ctrl_pkg.sv | 33 +++
 rtl/alu_ctrl_lut.sv | 37 +++
 rtl/alu_ctrl_queue.sv | 99 +++++++++
 tb/tb_alu_ctrl_queue.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control queue: ALUOp values from the main
// decoder, R-type funct values, and the 4-bit ALU control encoding.
package alu_ctrl_pkg;

  localparam logic [2:0] AOP_ADD   = 3'b000;
  localparam logic [2:0] AOP_SUB   = 3'b001;
  localparam logic [2:0] AOP_RTYPE = 3'b010;
  localparam logic [2:0] AOP_SLT   = 3'b011;
  localparam logic [2:0] AOP_OR    = 3'b100;
  localparam logic [2:0] AOP_AND   = 3'b101;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [3:0] CTRL_AND = 4'd0;
  localparam logic [3:0] CTRL_OR  = 4'd1;
  localparam logic [3:0] CTRL_ADD = 4'd2;
  localparam logic [3:0] CTRL_SUB = 4'd6;
  localparam logic [3:0] CTRL_SLT = 4'd7;
  localparam logic [3:0] CTRL_NOR = 4'd12;
  localparam logic [3:0] CTRL_ILL = 4'd15;

  // One queued entry: decoded ALU code plus the illegal-decode flag.
  typedef struct packed {
    logic [3:0] ctrl;
    logic       illegal;
  } ctrl_entry_t;

endpackage

// File: rtl/alu_ctrl_lut.sv
// Combinational (ALUOp, funct) -> ALU control decode. Anything not in the
// table decodes to CTRL_ILL with the illegal flag set.
module alu_ctrl_lut
  import alu_ctrl_pkg::*;
(
  input  logic [2:0] aluop,
  input  logic [5:0] funct,
  output logic [3:0] ctrl,
  output logic       illegal
);

  // Table decode; defaults cover every unlisted ALUOp / funct.
  always_comb begin
    ctrl    = CTRL_ILL;
    illegal = 1'b1;
    case (aluop)
      AOP_ADD: begin ctrl = CTRL_ADD; illegal = 1'b0; end
      AOP_SUB: begin ctrl = CTRL_SUB; illegal = 1'b0; end
      AOP_SLT: begin ctrl = CTRL_SLT; illegal = 1'b0; end
      AOP_OR:  begin ctrl = CTRL_OR;  illegal = 1'b0; end
      AOP_AND: begin ctrl = CTRL_AND; illegal = 1'b0; end
      AOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: begin ctrl = CTRL_ADD; illegal = 1'b0; end
          FUNCT_SUB: begin ctrl = CTRL_SUB; illegal = 1'b0; end
          FUNCT_AND: begin ctrl = CTRL_AND; illegal = 1'b0; end
          FUNCT_OR:  begin ctrl = CTRL_OR;  illegal = 1'b0; end
          FUNCT_NOR: begin ctrl = CTRL_NOR; illegal = 1'b0; end
          FUNCT_SLT: begin ctrl = CTRL_SLT; illegal = 1'b0; end
          default:   begin ctrl = CTRL_ILL; illegal = 1'b1; end
        endcase
      end
      default: begin ctrl = CTRL_ILL; illegal = 1'b1; end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_queue.sv
// ALU control queue: decodes (ALUOp, funct) at enqueue and buffers the result
// in a DEPTH-entry FIFO feeding the EX stage. No empty-queue bypass, so an
// entry reaches the head one edge after its push.
// Optional macro ALU_CTRL_ILLEGAL_CNT_EN adds a saturating illegal-push
// counter on illegal_cnt_o.
module alu_ctrl_queue
  import alu_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       aluop_i,
  input  logic [5:0]       funct_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [3:0]       ctrl_o,
  output logic             illegal_o
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
  ,
  output logic [CNT_W-1:0] illegal_cnt_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  // Elaboration-time sanity checks on the parameters.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  ctrl_entry_t mem [DEPTH];
  ctrl_entry_t dec_entry;
  ctrl_entry_t head;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;

  alu_ctrl_lut u_lut (
    .aluop   (aluop_i),
    .funct   (funct_i),
    .ctrl    (dec_entry.ctrl),
    .illegal (dec_entry.illegal)
  );

  // Status from pointer state only, so in_ready_o never depends on out_ready_i.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign push  = in_valid_i && !full;
  assign pop   = out_ready_i && !empty;

  assign in_ready_o  = !full;
  assign out_valid_o = !empty;
  assign head        = mem[rd_ptr[AW-1:0]];
  assign ctrl_o      = empty ? 4'd0 : head.ctrl;
  assign illegal_o   = empty ? 1'b0 : head.illegal;

  // Storage write; contents are don't-care until validated by the pointers.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= dec_entry;
  end

  // Pointer update; reset discards every queued entry.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

`ifdef ALU_CTRL_ILLEGAL_CNT_EN
  logic [CNT_W-1:0] illegal_cnt;

  // Count illegal pushes, holding at all-ones.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      illegal_cnt <= '0;
    end else if (push && dec_entry.illegal && (illegal_cnt != {CNT_W{1'b1}})) begin
      illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

  assign illegal_cnt_o = illegal_cnt;
`endif

endmodule

// File: tb/tb_alu_ctrl_queue.sv
// Bench for alu_ctrl_queue: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_alu_ctrl_queue;

  localparam int DEPTH = 2;
  localparam int CNT_W = 2;

  logic       clk_i       = 1'b0;
  logic       rst_i       = 1'b0;
  logic       in_valid_i  = 1'b0;
  logic       out_ready_i = 1'b0;
  logic [2:0] aluop_i     = 3'd0;
  logic [5:0] funct_i     = 6'd0;
  logic       in_ready_o;
  logic       out_valid_o;
  logic [3:0] ctrl_o;
  logic       illegal_o;
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
  logic [CNT_W-1:0] illegal_cnt_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [4:0] mq[$];   // {ctrl, illegal}, front = head
  int         m_cnt = 0;

  alu_ctrl_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .aluop_i       (aluop_i),
    .funct_i       (funct_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .ctrl_o        (ctrl_o),
    .illegal_o     (illegal_o)
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    ,
    .illegal_cnt_o (illegal_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [2:0] op, input logic [5:0] f);
    int rt_funct [6] = '{32, 34, 36, 37, 39, 42};
    int rt_code  [6] = '{2, 6, 0, 1, 12, 7};
    int op_code  [6] = '{2, 6, -1, 7, 1, 0};
    if (op <= 3'd5 && op != 3'd2) return {4'(op_code[op]), 1'b0};
    if (op == 3'd2)
      for (int i = 0; i < 6; i++)
        if (int'(f) == rt_funct[i]) return {4'(rt_code[i]), 1'b0};
    return {4'd15, 1'b1};
  endfunction

  task automatic check_outputs(input string tag);
    logic [4:0] hd;
    hd = (mq.size() != 0) ? mq[0] : 5'd0;
    chk({tag, ".valid"},   out_valid_o, (mq.size() != 0));
    chk({tag, ".ready"},   in_ready_o,  (mq.size() < DEPTH));
    chk({tag, ".ctrl"},    ctrl_o,      hd[4:1]);
    chk({tag, ".illegal"}, illegal_o,   hd[0]);
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    chk({tag, ".cnt"},     illegal_cnt_o, m_cnt);
`endif
  endtask

  // Drive one cycle of inputs (called just after a negedge), update the model
  // at the posedge, and compare at the following negedge.
  task automatic step(input logic v, input logic [2:0] op, input logic [5:0] f,
                      input logic r, input string tag);
    logic       do_push, do_pop;
    logic [4:0] e;
    in_valid_i  = v;
    aluop_i     = op;
    funct_i     = f;
    out_ready_i = r;
    do_push = v && (mq.size() < DEPTH);
    do_pop  = r && (mq.size() != 0);
    e = ref_decode(op, f);
    @(posedge clk_i);
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      mq.push_back(e);
      if (e[0] && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end
    @(negedge clk_i);
    check_outputs(tag);
  endtask

  task automatic model_reset();
    mq.delete();
    m_cnt = 0;
  endtask

  initial begin
    logic [5:0] sweep_f [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    int         sweep_c [6] = '{2, 6, 0, 1, 12, 7};
    logic [5:0] f;

    // Reset held low, then released
    @(negedge clk_i);
    chk("rst_hold.valid", out_valid_o, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    model_reset();
    @(negedge clk_i);
    chk("rst.valid", out_valid_o, 0);
    chk("rst.ready", in_ready_o, 1);
    chk("rst.ctrl", ctrl_o, 0);
    check_outputs("rst");

    // Decode sweep, one cycle after each push
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 3'd2, sweep_f[i], 1'b1, "sweep");
      chk("sweep.code", ctrl_o, sweep_c[i]);
    end
    step(1'b0, 3'd0, 6'd0, 1'b1, "drain");

    // Illegal decodes
    step(1'b1, 3'd2, 6'h08, 1'b1, "ill_f");
    chk("ill_f.ctrl", ctrl_o, 15);
    chk("ill_f.flag", illegal_o, 1);
    step(1'b1, 3'd7, 6'h20, 1'b1, "ill_op");
    chk("ill_op.ctrl", ctrl_o, 15);
    chk("ill_op.flag", illegal_o, 1);
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    chk("ill.cnt2", illegal_cnt_o, 2);
`endif
    step(1'b0, 3'd0, 6'd0, 1'b1, "drain");

    // Full / backpressure
    step(1'b1, 3'd0, 6'd0, 1'b0, "full1");
    chk("full1.ready", in_ready_o, 1);
    step(1'b1, 3'd1, 6'd0, 1'b0, "full2");
    chk("full2.ready", in_ready_o, 0);
    step(1'b1, 3'd4, 6'd0, 1'b0, "full3");
    chk("full3.head", ctrl_o, 2);
    step(1'b0, 3'd0, 6'd0, 1'b0, "hold");
    chk("hold.head", ctrl_o, 2);
    step(1'b0, 3'd0, 6'd0, 1'b1, "pop1");
    chk("pop1.head", ctrl_o, 6);
    step(1'b0, 3'd0, 6'd0, 1'b1, "pop2");
    chk("pop2.valid", out_valid_o, 0);

    // Simultaneous push/pop at occupancy 1 across pointer wrap
    step(1'b1, 3'd5, 6'd0, 1'b0, "wrap0");
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 3'($urandom_range(0, 5)), 6'h20, 1'b1, "wrap");
      chk("wrap.occ1", out_valid_o && in_ready_o, 1);
    end
    step(1'b0, 3'd0, 6'd0, 1'b1, "drain");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      f = ($urandom_range(0, 3) != 0) ? sweep_f[$urandom_range(0, 5)] : 6'($urandom);
      step(1'($urandom), 3'($urandom), f, 1'($urandom_range(0, 2) != 0), "rand");
    end

    // Asynchronous reset with an entry queued
    model_reset();
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    step(1'b1, 3'd0, 6'd0, 1'b0, "pre_arst");
    #2;
    rst_i = 1'b0;
    #1;
    model_reset();
    chk("arst.valid", out_valid_o, 0);
    chk("arst.ready", in_ready_o, 1);
    chk("arst.ctrl", ctrl_o, 0);
    in_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    step(1'b0, 3'd0, 6'd0, 1'b1, "post_arst");

    // Saturation: 5 illegal pushes with a 2-bit counter
    for (int i = 0; i < 5; i++) step(1'b1, 3'd6, 6'd0, 1'b1, "sat");
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    chk("sat.cnt3", illegal_cnt_o, 3);
`endif
    step(1'b0, 3'd0, 6'd0, 1'b1, "drain");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
